sr5_nand_window: RTL and testbench
==================================

# sr5_nand_window

Five-tap serial window register with registered NAND output, placed directly upstream of the SC 5-input NAND cell. Its taps drive the NAND inputs A..E, and it carries the same NAND function as a registered output. It also counts consecutive all-ones windows and raises a detect flag at a programmable threshold. The block is a simulation-library cell in the SC primitive set, behavioural and fully synchronous.

## Interface
- THRESH, default 3: number of consecutive all-ones windows that asserts DET. Legal range is 1..2^CNT_W-1.
- CNT_W, default 4: width of the run counter. The counter saturates at 2^CNT_W-1.

- CK, input, 1: clock. All state updates on the rising edge.
- LSR, input, 1: reset, synchronous and active-high.
- CE, input, 1: clock enable for shift, fill and run-count updates.
- SI, input, 1: serial data in, sampled at CK rise when CE=1.
- Q, output, 5: window taps. Q[0] is the newest bit and Q[4] the oldest. Q[4:0] maps to NAND inputs E, D, C, B, A.
- Z, output, 1: registered NAND of Q.
- VALID, output, 1: high once 5 CE-qualified shifts have occurred since reset.
- RUN, output, CNT_W: consecutive all-ones window count.
- DET, output, 1: high when RUN >= THRESH.

## Operation
- Reset: LSR=1 at a CK edge sets the following, overriding CE and SI.
  - Q=5'b00000
  - Z=1, which is the NAND of all zeros
  - fill counter=0 and VALID=0
  - RUN=0 and DET=0
- Shift: on an edge with CE=1, Q_next = {Q[3:0], SI}. With CE=0, Q holds.
- Fill counter:
  - 3 bits, counts 0..5.
  - Increments on each CE edge until it reaches 5, then holds at 5.
  - VALID = (fill == 5), decoded from the register.
- Z:
  - Z <= ~&Q on every non-reset edge, independent of CE.
  - Z therefore reflects the window present before the edge, one cycle behind Q.
- RUN counter, updated on a CE edge:
  - If &Q_next, RUN <= RUN+1, saturating at 2^CNT_W-1.
  - Otherwise RUN <= 0.
  - With CE=0, RUN holds.
  - &Q_next can only occur after at least 5 shifts of 1 since reset, so RUN>0 implies VALID=1.
- DET = (RUN >= THRESH), combinational from the RUN register, with no extra register stage.
- Reset mid-operation: a run in progress is discarded. VALID drops and Z returns to 1 on the same edge. Refill needs 5 new CE edges.
- CE low mid-run: Q, fill, RUN and DET are all frozen. Z keeps recomputing from the frozen Q, so it stays stable.
- Parameter check: an elaboration-time error is required if THRESH=0 or THRESH > 2^CNT_W-1.

## Timing
- SI to Q[0]: 1 edge.
- SI to Z: 2 edges. The bit enters Q on edge n and Z reflects it on edge n+1.
- SI completing an all-ones window to RUN increment: 1 edge. DET follows in the same cycle as RUN.
- LSR: takes effect on the edge where it is sampled high. All outputs are at reset values from that edge until the first edge with LSR=0.
- No combinational path from any input to any output.

## Test plan
- Reset values: assert LSR for 2 edges with SI=1 and CE=1.
  - Required: Q=0, Z=1, VALID=0, RUN=0, DET=0 throughout.
- Fill and NAND (THRESH=3): release LSR, then SI=1 and CE=1 for 5 edges.
  - Edge 5: Q=5'b11111, VALID=1, RUN=1, DET=0.
  - Edge 6: Z=0.
- Detect threshold: continue SI=1 for 2 more edges.
  - Edge 7: RUN=3 and DET=1.
  - Next edge with SI=0: Q=5'b11110, RUN=0 and DET=0 on that edge. Z=1 one edge later.
- CE hold: with RUN=2, drop CE for 4 edges while toggling SI.
  - Required: Q, RUN, VALID and DET unchanged. Z constant.
  - CE high with SI=1: RUN=3 and DET=1.
- Saturation (CNT_W=2, THRESH=3): apply 20 consecutive 1s.
  - Required: RUN reaches 3 and holds at 3, with no wrap to 0. DET stays 1.
- Reset mid-run: with RUN=4, pulse LSR for 1 edge with SI=1.
  - Required: all outputs at reset values on that edge.
  - Then 4 further 1s: VALID=0, RUN=0.
  - The 5th 1 gives VALID=1 and RUN=1.

Source files
------------

// File: rtl/sr5_nand_window.sv
// Five-tap serial window register feeding a 5-input NAND, with a registered NAND
// output, fill tracking and a saturating run counter of consecutive all-ones windows.
module sr5_nand_window #(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             CK,
  input  logic             LSR,
  input  logic             CE,
  input  logic             SI,
  output logic [4:0]       Q,
  output logic             Z,
  output logic             VALID,
  output logic [CNT_W-1:0] RUN,
  output logic             DET
);

  localparam int unsigned TAPS    = 5;
  localparam int unsigned FILL_W  = 3;
  localparam int unsigned RUN_MAX = (1 << CNT_W) - 1;

  // Reject thresholds the run counter can never reach (or that are always met).
  if (THRESH == 0 || THRESH > RUN_MAX) begin : g_bad_thresh
    $error("sr5_nand_window: THRESH must be in 1..2^CNT_W-1");
  end

  logic [FILL_W-1:0] fill;
  logic [4:0]        q_next;
  logic              win_ones;
  logic              run_sat;

  assign q_next   = {Q[3:0], SI};
  assign win_ones = &q_next;
  assign run_sat  = (RUN == CNT_W'(RUN_MAX));

  // Window, NAND, fill and run state; Z tracks the pre-edge window regardless of CE.
  always_ff @(posedge CK) begin
    if (LSR) begin
      Q    <= '0;
      Z    <= 1'b1;
      fill <= '0;
      RUN  <= '0;
    end else begin
      Z <= ~&Q;
      if (CE) begin
        Q <= q_next;
        if (fill != FILL_W'(TAPS)) begin
          fill <= fill + FILL_W'(1);
        end
        if (win_ones) begin
          if (!run_sat) begin
            RUN <= RUN + CNT_W'(1);
          end
        end else begin
          RUN <= '0;
        end
      end
    end
  end

  // Both flags are plain decodes of registered state.
  assign VALID = (fill == FILL_W'(TAPS));
  assign DET   = (RUN >= CNT_W'(THRESH));

endmodule

// File: tb/tb_sr5_nand_window.sv
// Scoreboard bench for sr5_nand_window: directed vectors push expected outputs,
// a monitor pops one entry per clock edge and compares.
module tb_sr5_nand_window;

  logic       ck;
  logic       a_lsr, a_ce, a_si;
  logic [4:0] a_q;
  logic       a_z, a_valid, a_det;
  logic [3:0] a_run;

  logic       b_lsr, b_ce, b_si;
  logic [4:0] b_q;
  logic       b_z, b_valid, b_det;
  logic [1:0] b_run;

  int total;
  int bad;

  typedef struct {
    logic       sel;
    logic [4:0] q;
    logic       z;
    logic       v;
    logic [3:0] run;
    logic       det;
    int         tag;
  } exp_t;

  exp_t sb[$];

  sr5_nand_window #(.THRESH(3), .CNT_W(4)) dut_a (
    .CK(ck), .LSR(a_lsr), .CE(a_ce), .SI(a_si),
    .Q(a_q), .Z(a_z), .VALID(a_valid), .RUN(a_run), .DET(a_det)
  );

  sr5_nand_window #(.THRESH(3), .CNT_W(2)) dut_b (
    .CK(ck), .LSR(b_lsr), .CE(b_ce), .SI(b_si),
    .Q(b_q), .Z(b_z), .VALID(b_valid), .RUN(b_run), .DET(b_det)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", nm, tag, act, exp);
    end
  endtask

  // Monitor: every clock edge presents a new output set; compare against the oldest expectation.
  always @(posedge ck) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.sel) begin
        check("a_q",     e.tag, 32'(a_q),     32'(e.q));
        check("a_z",     e.tag, 32'(a_z),     32'(e.z));
        check("a_valid", e.tag, 32'(a_valid), 32'(e.v));
        check("a_run",   e.tag, 32'(a_run),   32'(e.run));
        check("a_det",   e.tag, 32'(a_det),   32'(e.det));
      end else begin
        check("b_q",     e.tag, 32'(b_q),     32'(e.q));
        check("b_z",     e.tag, 32'(b_z),     32'(e.z));
        check("b_valid", e.tag, 32'(b_valid), 32'(e.v));
        check("b_run",   e.tag, 32'(b_run),   32'(e.run));
        check("b_det",   e.tag, 32'(b_det),   32'(e.det));
      end
    end
  end

  task automatic push(input logic sel, input logic [4:0] q, input logic z, input logic v,
                      input logic [3:0] run, input logic det, input int tag);
    exp_t e;
    e.sel = sel; e.q = q; e.z = z; e.v = v; e.run = run; e.det = det; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic step_a(input logic lsr, input logic ce, input logic si,
                        input logic [4:0] q, input logic z, input logic v,
                        input logic [3:0] run, input logic det, input int tag);
    @(negedge ck);
    a_lsr = lsr; a_ce = ce; a_si = si;
    push(1'b0, q, z, v, run, det, tag);
  endtask

  task automatic step_b(input logic lsr, input logic ce, input logic si,
                        input logic [4:0] q, input logic z, input logic v,
                        input logic [3:0] run, input logic det, input int tag);
    @(negedge ck);
    b_lsr = lsr; b_ce = ce; b_si = si;
    push(1'b1, q, z, v, run, det, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int rb;
    logic [4:0] qb;
    total = 0;
    bad   = 0;
    a_lsr = 1'b1; a_ce = 1'b1; a_si = 1'b1;
    b_lsr = 1'b1; b_ce = 1'b0; b_si = 1'b0;

    // Reset with SI=1, CE=1 held for two edges.
    step_a(1, 1, 1, 5'b00000, 1, 0, 0, 0, 1);
    step_a(1, 1, 1, 5'b00000, 1, 0, 0, 0, 2);
    // Fill with ones.
    step_a(0, 1, 1, 5'b00001, 1, 0, 0, 0, 3);
    step_a(0, 1, 1, 5'b00011, 1, 0, 0, 0, 4);
    step_a(0, 1, 1, 5'b00111, 1, 0, 0, 0, 5);
    step_a(0, 1, 1, 5'b01111, 1, 0, 0, 0, 6);
    step_a(0, 1, 1, 5'b11111, 1, 1, 1, 0, 7);
    step_a(0, 1, 1, 5'b11111, 0, 1, 2, 0, 8);
    step_a(0, 1, 1, 5'b11111, 0, 1, 3, 1, 9);
    // A zero breaks the run; Z recovers one edge later.
    step_a(0, 1, 0, 5'b11110, 0, 1, 0, 0, 10);
    step_a(0, 1, 1, 5'b11101, 1, 1, 0, 0, 11);
    step_a(0, 1, 1, 5'b11011, 1, 1, 0, 0, 12);
    step_a(0, 1, 1, 5'b10111, 1, 1, 0, 0, 13);
    step_a(0, 1, 1, 5'b01111, 1, 1, 0, 0, 14);
    step_a(0, 1, 1, 5'b11111, 1, 1, 1, 0, 15);
    step_a(0, 1, 1, 5'b11111, 0, 1, 2, 0, 16);
    // CE low with SI toggling: everything frozen.
    step_a(0, 0, 0, 5'b11111, 0, 1, 2, 0, 17);
    step_a(0, 0, 1, 5'b11111, 0, 1, 2, 0, 18);
    step_a(0, 0, 0, 5'b11111, 0, 1, 2, 0, 19);
    step_a(0, 0, 1, 5'b11111, 0, 1, 2, 0, 20);
    step_a(0, 1, 1, 5'b11111, 0, 1, 3, 1, 21);
    step_a(0, 1, 1, 5'b11111, 0, 1, 4, 1, 22);
    // Reset mid-run, then refill.
    step_a(1, 1, 1, 5'b00000, 1, 0, 0, 0, 23);
    step_a(0, 1, 1, 5'b00001, 1, 0, 0, 0, 24);
    step_a(0, 1, 1, 5'b00011, 1, 0, 0, 0, 25);
    step_a(0, 1, 1, 5'b00111, 1, 0, 0, 0, 26);
    step_a(0, 1, 1, 5'b01111, 1, 0, 0, 0, 27);
    step_a(0, 1, 1, 5'b11111, 1, 1, 1, 0, 28);
    step_a(0, 1, 1, 5'b11111, 0, 1, 2, 0, 29);

    // Saturation on the 2-bit counter: 20 ones.
    step_b(1, 1, 1, 5'b00000, 1, 0, 0, 0, 100);
    for (int k = 1; k <= 20; k++) begin
      qb = (k >= 5) ? 5'b11111 : 5'((32'd1 << k) - 1);
      rb = (k < 5) ? 0 : ((k - 4 > 3) ? 3 : k - 4);
      step_b(0, 1, 1, qb, (k >= 6) ? 1'b0 : 1'b1, (k >= 5) ? 1'b1 : 1'b0,
             4'(rb), (rb >= 3) ? 1'b1 : 1'b0, 100 + k);
    end

    repeat (3) @(negedge ck);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
